sub_serial_64: RTL
==================

SUB_SERIAL_64 -- requirements
Module: sub_serial_64

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 64 bits, processed as 8 bytes.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start_valid  input  1  request: operands are valid.
REQ-005 start_ready  output  1  block can accept a request.
REQ-006 source_element_0  input  64  minuend vector.
REQ-007 source_element_1  input  64  subtrahend vector.
REQ-008 element_width  input  2  element width: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = 64-bit.
REQ-009 input_borrow  input  1  borrow into the least-significant byte of every element.
REQ-010 target_element  output  64  difference vector.
REQ-011 output_borrow  output  8  bit e is the borrow out of element e; bits at or above 64/width are 0.
REQ-012 result_valid  output  1  target_element and output_borrow are valid.
REQ-013 result_ready  input  1  consumer accepts the result.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 start_ready SHALL be 1 only in IDLE, and result_valid SHALL be 1 only in DONE.
REQ-016 A request SHALL be accepted on a rising edge where start_valid and start_ready are both 1.
REQ-017 On acceptance the block SHALL latch both operands, element_width and input_borrow, clear byte_index to 0, clear target_element and output_borrow, and enter RUN.
REQ-018 Input changes after acceptance SHALL have no effect on the result in progress.
REQ-019 In RUN the block SHALL compute exactly one byte per cycle, in ascending byte order: diff = a[i] - b[i] - bin (mod 256), with bout = 1 when a[i] < b[i] + bin (unsigned, 9-bit compare).
REQ-020 bin SHALL be the latched input_borrow when byte i is the lowest byte of its element (i mod bytes-per-element = 0); otherwise bin SHALL be the bout of byte i-1.
REQ-021 When byte i is the top byte of its element, bout SHALL be written to output_borrow[i / bytes-per-element].
REQ-022 Bytes-per-element SHALL be 1, 2, 4 or 8 for element_width 00, 01, 10 or 11 respectively.
REQ-023 After byte 7 is processed the FSM SHALL move to DONE.
REQ-024 result_valid SHALL rise exactly 8 cycles after the accepting edge.
REQ-025 In DONE, target_element and output_borrow SHALL hold stable until result_valid and result_ready are both 1 on an edge; the FSM SHALL then return to IDLE.
REQ-026 Back-to-back operation: start_ready SHALL rise in the cycle after the handshake. There SHALL be no overlap of requests, and start_valid SHALL be ignored in RUN and DONE.
REQ-027 Once the FSM leaves DONE, target_element and output_borrow SHALL keep their last values until the next acceptance.

Reset
REQ-028 While reset_n = 0, regardless of clock: state = IDLE, byte_index = 0, target_element = 0, output_borrow = 0, result_valid = 0, start_ready = 1.
REQ-029 Reset asserted mid-RUN or in DONE SHALL abort the operation; no partial result SHALL be presented afterwards.

Verification
REQ-030 8-bit lanes: src0 = 0x0807060504030201, src1 = 0x0101010101010101, borrow 0, width 00 -> target 0x0706050403020100, output_borrow 0x00, result_valid 8 cycles after accept.
REQ-031 64-bit: src0 = 0x0, src1 = 0x1, borrow 0, width 11 -> target 0xFFFFFFFFFFFFFFFF, output_borrow 0x01.
REQ-032 16-bit: src0 = 0x0100000001000000, src1 = 0x0001000100010001, width 01 -> target 0x00FFFFFF00FFFFFF, output_borrow 0x05.
REQ-033 32-bit with input borrow: src0 = 0x0000000500000000, src1 = 0x0, borrow 1, width 10 -> target 0x00000004FFFFFFFF, output_borrow 0x01.
REQ-034 Backpressure: hold result_ready = 0 for 5 cycles in DONE and toggle inputs and start_valid -> outputs stable, start_ready = 0, no new acceptance; the handshake then returns to IDLE.
REQ-035 Reset at the 4th RUN cycle -> all outputs 0 and start_ready = 1 immediately; the next request completes correctly per REQ-030.

Source files
------------

// File: rtl/sub_serial_64.sv
`default_nettype none
// ============================================================================
//  Module      : sub_serial_64
//  Description : Byte-serial packed-SIMD subtractor. One 64-bit operand pair
//                is accepted per request and processed one byte per cycle,
//                least-significant byte first. Element width selects how
//                borrows chain between bytes (8/16/32/64-bit lanes).
//  Ports       : clock, reset_n            - clock, async active-low reset
//                start_valid / start_ready - request handshake
//                source_element_0 / _1     - minuend / subtrahend vectors
//                element_width             - 00=8b, 01=16b, 10=32b, 11=64b
//                input_borrow              - borrow into every element
//                target_element            - difference vector
//                output_borrow             - borrow out per element
//                result_valid / result_ready - result handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_serial_64 (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [63:0] source_element_0,
    input  logic [63:0] source_element_1,
    input  logic [1:0]  element_width,
    input  logic        input_borrow,
    output logic [63:0] target_element,
    output logic [7:0]  output_borrow,
    output logic        result_valid,
    input  logic        result_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [1:0]  r_width;
    logic        r_bin;
    logic        r_carry;       // borrow out of the previous byte
    logic [2:0]  r_byte_idx;
    logic [63:0] r_target;
    logic [7:0]  r_out_borrow;
    logic        r_start_ready;
    logic        r_result_valid;

    logic [2:0]  w_mask;        // bytes-per-element minus one
    logic        w_low_byte;
    logic        w_top_byte;
    logic [2:0]  w_elem;
    logic        w_bin;
    logic [7:0]  w_a_byte;
    logic [7:0]  w_b_byte;
    logic [8:0]  w_diff9;

    always_comb begin
        w_mask = 3'b000;
        case (r_width)
            2'b00:   w_mask = 3'b000;
            2'b01:   w_mask = 3'b001;
            2'b10:   w_mask = 3'b011;
            default: w_mask = 3'b111;
        endcase
    end

    assign w_low_byte = ((r_byte_idx & w_mask) == 3'b000);
    assign w_top_byte = ((r_byte_idx & w_mask) == w_mask);
    assign w_elem     = r_byte_idx >> r_width;
    assign w_bin      = w_low_byte ? r_bin : r_carry;
    assign w_a_byte   = r_a[r_byte_idx*8 +: 8];
    assign w_b_byte   = r_b[r_byte_idx*8 +: 8];
    // 9-bit difference: bit 8 is set exactly when a < b + bin (unsigned).
    assign w_diff9    = {1'b0, w_a_byte} - {1'b0, w_b_byte} - {8'd0, w_bin};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_a            <= 64'd0;
            r_b            <= 64'd0;
            r_width        <= 2'b00;
            r_bin          <= 1'b0;
            r_carry        <= 1'b0;
            r_byte_idx     <= 3'd0;
            r_target       <= 64'd0;
            r_out_borrow   <= 8'd0;
            r_start_ready  <= 1'b1;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_a           <= source_element_0;
                        r_b           <= source_element_1;
                        r_width       <= element_width;
                        r_bin         <= input_borrow;
                        r_carry       <= 1'b0;
                        r_byte_idx    <= 3'd0;
                        r_target      <= 64'd0;
                        r_out_borrow  <= 8'd0;
                        r_start_ready <= 1'b0;
                        r_state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_target[r_byte_idx*8 +: 8] <= w_diff9[7:0];
                    r_carry                     <= w_diff9[8];
                    if (w_top_byte) begin
                        r_out_borrow[w_elem] <= w_diff9[8];
                    end
                    r_byte_idx <= r_byte_idx + 3'd1;
                    if (r_byte_idx == 3'd7) begin
                        r_result_valid <= 1'b1;
                        r_state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_start_ready  <= 1'b1;
                        r_state        <= S_IDLE;
                    end
                end
                default: begin
                    r_result_valid <= 1'b0;
                    r_start_ready  <= 1'b1;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

    assign start_ready    = r_start_ready;
    assign result_valid   = r_result_valid;
    assign target_element = r_target;
    assign output_borrow  = r_out_borrow;

endmodule
`default_nettype wire
